// File: rtl/pad_window_syn_param_if.sv
// Pad hit window bundle: config, sample input and synthesized window outputs.
// Latency: n/a (wires only).
// Backpressure: none; samples are accepted on every pad_data_valid cycle.
interface pad_window_syn_param_if #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic              pad_hit_clear;
  logic [DEPTH-1:0]  cfg_mask;
  logic              cfg_load;
  logic [WIDTH-1:0]  pad_data;
  logic              pad_data_valid;

  logic [WIDTH-1:0]  pad_data_syn;
  logic              pad_data_valid_out;
  logic              pad_hit_any;
  logic              window_full;
  logic [CNT_W-1:0]  hit_count;

  // Producer side: drives samples/config, observes the window result.
  modport master (
    output pad_hit_clear, cfg_mask, cfg_load, pad_data, pad_data_valid,
    input  pad_data_syn, pad_data_valid_out, pad_hit_any, window_full, hit_count
  );

  // Window block side.
  modport slave (
    input  pad_hit_clear, cfg_mask, cfg_load, pad_data, pad_data_valid,
    output pad_data_syn, pad_data_valid_out, pad_hit_any, window_full, hit_count
  );
endinterface

// File: rtl/pad_window_syn_param.sv
// Sliding history of pad hit vectors, OR-synthesized over a configurable stage mask.
// Latency: 1 cycle from an accepted sample to pad_data_syn / pad_data_valid_out.
// Backpressure: none; every valid cycle is consumed. Macro PAD_WINDOW_POPCNT_EN adds hit_count.
module pad_window_syn_param #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pad_window_syn_param_if.slave bus
);
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(DEPTH);

  typedef enum logic {FILL, RUN} state_e;

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;

  logic [WIDTH-1:0]  hist_q [DEPTH];
  logic [DEPTH-1:0]  mask_q;
  logic [WIDTH-1:0]  syn_q, syn_d;
  logic              vld_out_q;
  logic              accept;

  // A clear discards any sample presented in the same cycle; rst priority is in the flops.
  assign accept = bus.pad_data_valid & ~bus.pad_hit_clear;

  // Window OR over the pre-shift history using the currently active mask.
  always_comb begin
    syn_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      syn_d = syn_d | (hist_q[k] & {WIDTH{mask_q[k]}});
    end
  end

  // Active mask: loads on cfg_load regardless of clear; reset restores all stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '1;
    end else if (bus.cfg_load) begin
      mask_q <= bus.cfg_mask;
    end
  end

  // History shift register; unfilled stages stay zero so FILL output is well defined.
  always_ff @(posedge clk) begin
    if (rst || bus.pad_hit_clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= '0;
      end
    end else if (accept) begin
      hist_q[0] <= bus.pad_data;
      for (int k = 1; k < DEPTH; k++) begin
        hist_q[k] <= hist_q[k-1];
      end
    end
  end

  // Synthesized output register and its one-cycle update strobe.
  always_ff @(posedge clk) begin
    if (rst || bus.pad_hit_clear) begin
      syn_q     <= '0;
      vld_out_q <= 1'b0;
    end else begin
      vld_out_q <= accept;
      if (accept) begin
        syn_q <= syn_d;
      end
    end
  end

  // Fill FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Fill FSM next state: count accepted samples until the window holds DEPTH of them.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (bus.pad_hit_clear) begin
      state_d    = FILL;
      fill_cnt_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (fill_cnt_q == FILL_LAST) begin
              state_d    = RUN;
              fill_cnt_d = FILL_DONE;
            end else begin
              fill_cnt_d = fill_cnt_q + 1'b1;
            end
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      endcase
    end
  end

  assign bus.pad_data_syn       = syn_q;
  assign bus.pad_data_valid_out = vld_out_q;
  assign bus.pad_hit_any        = |syn_q;
  assign bus.window_full        = (state_q == RUN);

`ifdef PAD_WINDOW_POPCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Popcount of the value about to be loaded into pad_data_syn.
  always_comb begin
    cnt_d = '0;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_d = cnt_d + CNT_W'(syn_d[b]);
    end
  end

  // hit_count tracks pad_data_syn: cleared with it and updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst || bus.pad_hit_clear) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.hit_count = cnt_q;
`else
  assign bus.hit_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pad_window_syn_param.sv
// Self-checking bench for pad_window_syn_param: directed scenarios then random traffic
// against a queue-based reference model of the sample window.
module tb_pad_window_syn_param;
  localparam int WIDTH = 104;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pad_window_syn_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pad_window_syn_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: newest accepted sample at index 0.
  logic [WIDTH-1:0] m_hist [$];
  logic [DEPTH-1:0] m_mask;
  logic [WIDTH-1:0] m_syn;
  logic             m_vout;
  int               m_acc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_data(input int density);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r;
    d = '1;
    for (int j = 0; j < density; j++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      d = d & r;
    end
    return d;
  endfunction

  // Apply one cycle of inputs, advance the model, then compare every output.
  task automatic step(input logic r, input logic clr, input logic vld,
                      input logic [WIDTH-1:0] data, input logic ld,
                      input logic [DEPTH-1:0] msk);
    logic [WIDTH-1:0] acc_or;
    int exp_cnt;
    @(negedge clk);
    rst                = r;
    bus.pad_hit_clear  = clr;
    bus.pad_data_valid = vld;
    bus.pad_data       = data;
    bus.cfg_load       = ld;
    bus.cfg_mask       = msk;
    @(posedge clk);
    if (r) begin
      m_hist.delete();
      m_mask = '1;
      m_syn  = '0;
      m_vout = 1'b0;
      m_acc  = 0;
    end else begin
      if (clr) begin
        m_hist.delete();
        m_syn  = '0;
        m_vout = 1'b0;
        m_acc  = 0;
      end else begin
        m_vout = vld;
        if (vld) begin
          acc_or = '0;
          for (int i = 0; i < m_hist.size(); i++)
            if (m_mask[i]) acc_or = acc_or | m_hist[i];
          m_syn = acc_or;
          m_hist.push_front(data);
          if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
          m_acc++;
        end
      end
      if (ld) m_mask = msk;
    end
    #1;
`ifdef PAD_WINDOW_POPCNT_EN
    exp_cnt = $countones(m_syn);
`else
    exp_cnt = 0;
`endif
    check("pad_data_syn",       128'(bus.pad_data_syn),       128'(m_syn));
    check("pad_data_valid_out", 128'(bus.pad_data_valid_out), 128'(m_vout));
    check("pad_hit_any",        128'(bus.pad_hit_any),        128'(m_syn != '0));
    check("window_full",        128'(bus.window_full),        128'(m_acc >= DEPTH));
    check("hit_count",          128'(bus.hit_count),          128'(exp_cnt));
  endtask

  task automatic sample(input logic [WIDTH-1:0] data);
    step(1'b0, 1'b0, 1'b1, data, 1'b0, '0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [WIDTH-1:0] one;
    logic [WIDTH-1:0] ff_val;
    logic [WIDTH-1:0] held;
    one    = 1;
    ff_val = 'hFF;
    rst = 1'b1;
    bus.pad_hit_clear  = 1'b0;
    bus.pad_data_valid = 1'b0;
    bus.pad_data       = '0;
    bus.cfg_load       = 1'b0;
    bus.cfg_mask       = '0;
    m_mask = '1; m_syn = '0; m_vout = 1'b0; m_acc = 0;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    check("reset_syn_zero", 128'(bus.pad_data_syn), 128'(0));
    check("reset_full_zero", 128'(bus.window_full), 128'(0));

    // Fill with one-hot samples; window_full rises right after the 8th.
    for (int i = 0; i < DEPTH; i++) begin
      sample(one << i);
      if (i == DEPTH - 2) check("full_before_8th", 128'(bus.window_full), 128'(0));
    end
    check("full_after_8th", 128'(bus.window_full), 128'(1));
    sample('0);
    check("ninth_syn_ff", 128'(bus.pad_data_syn), 128'(ff_val));
    check("ninth_any", 128'(bus.pad_hit_any), 128'(1));
    check("ninth_vout", 128'(bus.pad_data_valid_out), 128'(1));
`ifdef PAD_WINDOW_POPCNT_EN
    check("popcnt_ff", 128'(bus.hit_count), 128'(8));
`else
    check("popcnt_off", 128'(bus.hit_count), 128'(0));
`endif

    // Mask load with a sample on the same edge: that sample still sees the old mask.
    step(1'b0, 1'b0, 1'b1, 'h5, 1'b1, 8'h01);
    check("load_old_mask", 128'(bus.pad_data_syn), 128'('hFE));
    sample('0);
    check("load_new_mask", 128'(bus.pad_data_syn), 128'('h5));

    // Clear with a sample in RUN: sample discarded, everything zero.
    step(1'b0, 1'b1, 1'b1, '1, 1'b0, '0);
    check("clear_vout", 128'(bus.pad_data_valid_out), 128'(0));
    check("clear_full", 128'(bus.window_full), 128'(0));
    sample(rnd_data(1));
    check("post_clear_syn", 128'(bus.pad_data_syn), 128'(0));

    // Idle gap mid-stream: output holds, no strobe.
    step(1'b0, 1'b0, 1'b1, '0, 1'b1, '1);
    sample(rnd_data(2));
    sample(rnd_data(2));
    held = bus.pad_data_syn;
    for (int i = 0; i < 5; i++) idle();
    check("idle_hold", 128'(bus.pad_data_syn), 128'(held));

    // Clear with a simultaneous mask load: both take effect.
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 8'h0F);
    for (int i = 0; i < 4; i++) sample(rnd_data(2));

    // Reset mid-fill: mask back to all ones, a full 8 samples needed again.
    step(1'b1, 1'b1, 1'b1, '1, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      sample(one << (i + 20));
      if (i == DEPTH - 2) check("refill_not_full", 128'(bus.window_full), 128'(0));
    end
    check("refill_full", 128'(bus.window_full), 128'(1));
    sample('0);
    check("reset_mask_all", 128'(bus.pad_data_syn), 128'(ff_val << 20));

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic r, c, v, l;
      r = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 9) == 0);
      step(r, c, v, rnd_data($urandom_range(1, 4)), l, DEPTH'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
